// File: rtl/bcd_sync_counter.sv
// Two-digit synchronous BCD up/down counter with programmable terminal value,
// enable prescaler, parallel load and one-cycle wrap/step pulses. Feeds the
// BCD-to-seven-segment decoders, so digit outputs always stay within 0..9.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   synchronous active-high reset
//   en         in   count enable; prescaler and digits hold when low
//   up         in   direction, 1 = increment, 0 = decrement
//   load       in   synchronous parallel load strobe (beats counting)
//   load_tens  in   BCD tens value to load
//   load_units in   BCD units value to load
//   tens       out  registered BCD tens digit
//   units      out  registered BCD units digit
//   carry      out  one-cycle pulse coincident with the wrapped value
//   step       out  one-cycle pulse whenever counting changed the digits
module bcd_sync_counter #(
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned MAX_TENS  = 5,
  parameter int unsigned MAX_UNITS = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       carry,
  output logic       step
);

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);
  localparam logic [3:0] MaxT = 4'(MAX_TENS);
  localparam logic [3:0] MaxU = 4'(MAX_UNITS);

  logic [PsW-1:0] ps_q, ps_d;
  logic [3:0]     tens_q, tens_d;
  logic [3:0]     units_q, units_d;
  logic           carry_q, carry_d;
  logic           step_q, step_d;
  logic           do_step;
  logic           at_max, at_zero, load_ok;

  assign do_step = en && (ps_q == PsLast);
  assign at_max  = (tens_q == MaxT) && (units_q == MaxU);
  assign at_zero = (tens_q == 4'd0) && (units_q == 4'd0);
  // Valid BCD digits order the same as their numeric value, so the 8-bit
  // concatenation compares correctly against the terminal value.
  assign load_ok = (load_tens <= 4'd9) && (load_units <= 4'd9) &&
                   ({load_tens, load_units} <= {MaxT, MaxU});

  always_comb begin
    ps_d    = ps_q;
    tens_d  = tens_q;
    units_d = units_q;
    carry_d = 1'b0;
    step_d  = 1'b0;

    if (en) begin
      ps_d = do_step ? '0 : ps_q + 1'b1;
    end

    if (do_step) begin
      step_d = 1'b1;
      if (up) begin
        if (at_max) begin
          tens_d  = 4'd0;
          units_d = 4'd0;
          carry_d = 1'b1;
        end else if (units_q == 4'd9) begin
          units_d = 4'd0;
          tens_d  = tens_q + 4'd1;
        end else begin
          units_d = units_q + 4'd1;
        end
      end else begin
        if (at_zero) begin
          tens_d  = MaxT;
          units_d = MaxU;
          carry_d = 1'b1;
        end else if (units_q == 4'd0) begin
          units_d = 4'd9;
          tens_d  = tens_q - 4'd1;
        end else begin
          units_d = units_q - 4'd1;
        end
      end
    end

    // Load suppresses any coincident step and restarts the prescaler.
    if (load) begin
      ps_d    = '0;
      carry_d = 1'b0;
      step_d  = 1'b0;
      tens_d  = load_ok ? load_tens  : 4'd0;
      units_d = load_ok ? load_units : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q    <= '0;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      carry_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      carry_q <= carry_d;
      step_q  <= step_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;
  assign carry = carry_q;
  assign step  = step_q;

endmodule

// File: tb/tb_bcd_sync_counter.sv
// Self-checking bench for bcd_sync_counter. Three instances share stimulus:
// default (mod 60, PRESCALE 1), prescaled (mod 60, PRESCALE 4) and mod 10.
// An arithmetic model (value as an integer modulo the count range) tracks
// each instance every cycle; directed tables and sequences add fixed values.
module tb_bcd_sync_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, load;
  logic [3:0] load_tens, load_units;

  logic [3:0] t0, u0, t1, u1, t2, u2;
  logic       c0, s0, c1, s1, c2, s2;

  always #5 clk = ~clk;

  bcd_sync_counter #(.PRESCALE(1), .MAX_TENS(5), .MAX_UNITS(9)) u_dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_tens(load_tens), .load_units(load_units),
    .tens(t0), .units(u0), .carry(c0), .step(s0)
  );

  bcd_sync_counter #(.PRESCALE(4), .MAX_TENS(5), .MAX_UNITS(9)) u_ps4 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_tens(load_tens), .load_units(load_units),
    .tens(t1), .units(u1), .carry(c1), .step(s1)
  );

  bcd_sync_counter #(.PRESCALE(1), .MAX_TENS(0), .MAX_UNITS(9)) u_m10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_tens(load_tens), .load_units(load_units),
    .tens(t2), .units(u2), .carry(c2), .step(s2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: value as a plain integer, enabled-cycle count since last step.
  int mod_a [3] = '{60, 60, 10};
  int pre_a [3] = '{1, 4, 1};
  int mv [3];
  int mp [3];
  bit mc [3];
  bit ms [3];

  logic [9:0] obs [3];
  assign obs[0] = {t0, u0, c0, s0};
  assign obs[1] = {t1, u1, c1, s1};
  assign obs[2] = {t2, u2, c2, s2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int lv;
    for (int i = 0; i < 3; i++) begin
      mc[i] = 1'b0;
      ms[i] = 1'b0;
      if (reset) begin
        mv[i] = 0;
        mp[i] = 0;
      end else if (load) begin
        mp[i] = 0;
        lv = int'(load_tens) * 10 + int'(load_units);
        if (load_tens <= 9 && load_units <= 9 && lv < mod_a[i]) mv[i] = lv;
        else mv[i] = 0;
      end else if (en) begin
        mp[i] = mp[i] + 1;
        if (mp[i] == pre_a[i]) begin
          mp[i] = 0;
          ms[i] = 1'b1;
          if (up) begin
            mc[i] = (mv[i] == mod_a[i] - 1);
            mv[i] = (mv[i] + 1) % mod_a[i];
          end else begin
            mc[i] = (mv[i] == 0);
            mv[i] = (mv[i] + mod_a[i] - 1) % mod_a[i];
          end
        end
      end
    end
  endtask

  task automatic check_model();
    logic [9:0] e;
    for (int i = 0; i < 3; i++) begin
      e = {4'(mv[i] / 10), 4'(mv[i] % 10), mc[i], ms[i]};
      check($sformatf("model_inst%0d", i), 32'(obs[i]), 32'(e));
    end
    check("m10_range", 32'((t2 == 4'd0) && (u2 <= 4'd9)), 32'd1);
  endtask

  // Inputs are stable across the edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  task automatic drive(input bit r, input bit e, input bit u, input bit l,
                       input logic [3:0] lt, input logic [3:0] lu);
    reset = r; en = e; up = u; load = l; load_tens = lt; load_units = lu;
  endtask

  typedef struct {
    bit         rst, en, up, ld;
    logic [3:0] lt, lu;
    logic [3:0] et, eu;
    bit         ec, es;
  } vec_t;

  vec_t vecs [16];
  int   carries;

  initial begin
    // Expectations for the default instance (mod 60, PRESCALE 1).
    vecs[0]  = '{1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd0, 0, 0};
    vecs[1]  = '{0, 1, 1, 0, 4'd0, 4'd0,  4'd0, 4'd1, 0, 1};
    vecs[2]  = '{0, 1, 1, 1, 4'd5, 4'd8,  4'd5, 4'd8, 0, 0};
    vecs[3]  = '{0, 1, 1, 0, 4'd0, 4'd0,  4'd5, 4'd9, 0, 1};
    vecs[4]  = '{0, 1, 1, 0, 4'd0, 4'd0,  4'd0, 4'd0, 1, 1};
    vecs[5]  = '{0, 1, 0, 0, 4'd0, 4'd0,  4'd5, 4'd9, 1, 1};
    vecs[6]  = '{0, 1, 0, 0, 4'd0, 4'd0,  4'd5, 4'd8, 0, 1};
    vecs[7]  = '{0, 0, 0, 1, 4'd1, 4'd0,  4'd1, 4'd0, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 4'd0, 4'd0,  4'd0, 4'd9, 0, 1};
    vecs[9]  = '{0, 0, 1, 1, 4'd6, 4'd2,  4'd0, 4'd0, 0, 0};
    vecs[10] = '{0, 0, 1, 1, 4'd3, 4'd12, 4'd0, 4'd0, 0, 0};
    vecs[11] = '{0, 1, 1, 1, 4'd4, 4'd7,  4'd4, 4'd7, 0, 0};
    vecs[12] = '{0, 0, 1, 0, 4'd0, 4'd0,  4'd4, 4'd7, 0, 0};
    vecs[13] = '{0, 0, 1, 1, 4'd5, 4'd9,  4'd5, 4'd9, 0, 0};
    vecs[14] = '{1, 1, 1, 0, 4'd0, 4'd0,  4'd0, 4'd0, 0, 0};
    vecs[15] = '{0, 1, 1, 0, 4'd0, 4'd0,  4'd0, 4'd1, 0, 1};

    for (int i = 0; i < 3; i++) begin
      mv[i] = 0; mp[i] = 0; mc[i] = 0; ms[i] = 0;
    end

    drive(1, 0, 1, 0, 4'd0, 4'd0);
    tick();
    check("reset_state", 32'({t0, u0, c0, s0}), 32'd0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].lt, vecs[i].lu);
      tick();
      check($sformatf("vec%0d", i), 32'({t0, u0, c0, s0}),
            32'({vecs[i].et, vecs[i].eu, vecs[i].ec, vecs[i].es}));
    end

    // Full up-count over the default modulus: carry only with the 00 after 59.
    drive(1, 0, 1, 0, 4'd0, 4'd0);
    tick();
    drive(0, 1, 1, 0, 4'd0, 4'd0);
    carries = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      check("seq60_value", 32'(t0 * 10 + u0), 32'(k % 60));
      check("seq60_step", 32'(s0), 32'd1);
      if (c0) carries++;
    end
    check("seq60_carry_count", 32'(carries), 32'd1);
    check("seq60_end_carry", 32'(c0), 32'd1);

    // Prescaler: one step per 4 enabled cycles, frozen while en is low.
    drive(1, 0, 1, 0, 4'd0, 4'd0);
    tick();
    drive(0, 1, 1, 0, 4'd0, 4'd0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("ps4_step", 32'(s1), 32'((k % 4) == 0));
    end
    check("ps4_after12", 32'({t1, u1}), 32'h03);
    tick();
    tick();
    drive(0, 0, 1, 0, 4'd0, 4'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("ps4_hold", 32'({t1, u1, s1}), 32'({8'h03, 1'b0}));
    end
    drive(0, 1, 1, 0, 4'd0, 4'd0);
    tick();
    check("ps4_resume_wait", 32'(s1), 32'd0);
    tick();
    check("ps4_resume_step", 32'({t1, u1, s1}), 32'({8'h04, 1'b1}));

    // Mod-10 instance: wraps 9 -> 0 with carry, twice in 25 steps.
    drive(1, 0, 1, 0, 4'd0, 4'd0);
    tick();
    drive(0, 1, 1, 0, 4'd0, 4'd0);
    carries = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (c2) begin
        carries++;
        check("m10_wrap_value", 32'({t2, u2}), 32'h00);
      end
    end
    check("m10_carry_count", 32'(carries), 32'd2);

    // Randomized stimulus against the model.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom),
            ($urandom_range(15) == 0), 4'($urandom), 4'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
